// File: rtl/csi2_chk_pkg.sv
// Shared types and the reference test pattern for the CSI-2 RX frame checker.
package csi2_chk_pkg;

    typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} chk_state_t;

    localparam int BYTES_PER_BEAT = 4;

    // Byte k of beat w on line L carries (L + 4*w + k) mod 256.
    function automatic logic [31:0] exp_word(input logic [7:0] line,
                                             input logic [7:0] word);
        logic [7:0]  base;
        logic [31:0] w;
        base = line + (word << 2);
        w    = '0;
        for (int k = 0; k < BYTES_PER_BEAT; k++)
            w[8*k +: 8] = base + 8'(k);
        return w;
    endfunction

endpackage

// File: rtl/csi2_pattern_gen.sv
// Registered expected-word generator; holds the pattern for the next beat
// so the checker compares without adding latency.
module csi2_pattern_gen
    import csi2_chk_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        adv_i,
    input  logic        last_i,
    output logic [31:0] exp_o
);

    logic [7:0]  line_q, line_d;
    logic [7:0]  word_q, word_d;
    logic [31:0] exp_q;

    always_comb begin
        line_d = line_q;
        word_d = word_q;
        if (clr_i) begin
            line_d = '0;
            word_d = '0;
        end else if (adv_i) begin
            if (last_i) begin
                line_d = line_q + 8'd1;
                word_d = '0;
            end else begin
                word_d = word_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_q <= '0;
            word_q <= '0;
            exp_q  <= exp_word(8'd0, 8'd0);
        end else begin
            line_q <= line_d;
            word_q <= word_d;
            exp_q  <= exp_word(line_d, word_d);
        end
    end

    assign exp_o = exp_q;

endmodule

// File: rtl/csi2_rx_frame_checker.sv
// Frame geometry and payload checker sitting on the CSI-2 RX AXI4-Stream output.
// Status is registered; sticky flags and counters clear on clear_errs.
module csi2_rx_frame_checker
    import csi2_chk_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_LINE  = 640,
    parameter int LINES_PER_FRAME = 480,
    parameter int CNT_WIDTH       = 16,
    parameter int CHECK_PATTERN   = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  enable,
    input  logic                  clear_errs,
    input  logic                  fs,
    input  logic                  fe,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [31:0]           frame_count,
    output logic [31:0]           good_frames,
    output logic [CNT_WIDTH-1:0]  last_line_words,
    output logic [CNT_WIDTH-1:0]  last_frame_lines,
    output logic                  err_line_len,
    output logic                  err_line_cnt,
    output logic                  err_data,
    output logic                  err_framing,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] WPL = CNT_WIDTH'(WORDS_PER_LINE);
    localparam logic [CNT_WIDTH-1:0] LPF = CNT_WIDTH'(LINES_PER_FRAME);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    chk_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] llw_q, llw_d;
    logic [CNT_WIDTH-1:0] lfl_q, lfl_d;
    logic [31:0]          fcnt_q, fcnt_d;
    logic [31:0]          good_q, good_d;
    logic                 ferr_q, ferr_d;
    logic                 e_len_q, e_len_d;
    logic                 e_cnt_q, e_cnt_d;
    logic                 e_dat_q, e_dat_d;
    logic                 e_frm_q, e_frm_d;
    logic                 done_q, done_d;
    logic                 tready_q;
    logic                 beat;
    logic                 gen_clr;
    logic                 gen_adv;
    logic [31:0]          exp_w;

    assign beat = s_axis_tvalid & tready_q;

    csi2_pattern_gen u_pgen (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .clr_i  (gen_clr),
        .adv_i  (gen_adv),
        .last_i (s_axis_tlast),
        .exp_o  (exp_w)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        llw_d      = llw_q;
        lfl_d      = lfl_q;
        fcnt_d     = fcnt_q;
        good_d     = good_q;
        ferr_d     = ferr_q;
        e_len_d    = e_len_q;
        e_cnt_d    = e_cnt_q;
        e_dat_d    = e_dat_q;
        e_frm_d    = e_frm_q;
        done_d     = 1'b0;
        gen_clr    = 1'b0;
        gen_adv    = 1'b0;
        if (clear_errs) begin
            llw_d   = '0;
            lfl_d   = '0;
            fcnt_d  = '0;
            good_d  = '0;
            e_len_d = 1'b0;
            e_cnt_d = 1'b0;
            e_dat_d = 1'b0;
            e_frm_d = 1'b0;
        end
        if (!enable) begin
            state_d = ST_IDLE;
            gen_clr = 1'b1;
        end else begin
            if (state_q == ST_IDLE) begin
                if (fe)
                    e_frm_d = 1'b1;
                if (fs) begin
                    state_d    = ST_ACTIVE;
                    word_cnt_d = '0;
                    line_cnt_d = '0;
                    ferr_d     = 1'b0;
                end else begin
                    gen_clr = 1'b1;
                    if (beat)
                        e_frm_d = 1'b1;
                end
            end
            // A beat alongside fs in IDLE is the new frame's first beat.
            if (beat && (state_q == ST_ACTIVE || fs)) begin
                gen_adv = 1'b1;
                if (CHECK_PATTERN != 0 && s_axis_tdata != exp_w) begin
                    e_dat_d = 1'b1;
                    ferr_d  = 1'b1;
                end
                if (s_axis_tlast) begin
                    llw_d = sat_inc(word_cnt_d);
                    if (sat_inc(word_cnt_d) != WPL) begin
                        e_len_d = 1'b1;
                        ferr_d  = 1'b1;
                    end
                    word_cnt_d = '0;
                    line_cnt_d = sat_inc(line_cnt_d);
                end else begin
                    word_cnt_d = sat_inc(word_cnt_d);
                end
            end
            if (state_q == ST_ACTIVE) begin
                if (fe) begin
                    lfl_d = line_cnt_d;
                    if (line_cnt_d != LPF) begin
                        e_cnt_d = 1'b1;
                        ferr_d  = 1'b1;
                    end
                    if (word_cnt_d != '0) begin
                        e_len_d = 1'b1;
                        ferr_d  = 1'b1;
                    end
                    fcnt_d = fcnt_d + 32'd1;
                    if (!ferr_d)
                        good_d = good_d + 32'd1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    gen_clr = 1'b1;
                end
                if (fs) begin
                    if (!fe)
                        e_frm_d = 1'b1;
                    word_cnt_d = '0;
                    line_cnt_d = '0;
                    ferr_d     = 1'b0;
                    state_d    = ST_ACTIVE;
                    gen_clr    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            llw_q      <= '0;
            lfl_q      <= '0;
            fcnt_q     <= '0;
            good_q     <= '0;
            ferr_q     <= 1'b0;
            e_len_q    <= 1'b0;
            e_cnt_q    <= 1'b0;
            e_dat_q    <= 1'b0;
            e_frm_q    <= 1'b0;
            done_q     <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            llw_q      <= llw_d;
            lfl_q      <= lfl_d;
            fcnt_q     <= fcnt_d;
            good_q     <= good_d;
            ferr_q     <= ferr_d;
            e_len_q    <= e_len_d;
            e_cnt_q    <= e_cnt_d;
            e_dat_q    <= e_dat_d;
            e_frm_q    <= e_frm_d;
            done_q     <= done_d;
            tready_q   <= 1'b1;
        end
    end

    assign s_axis_tready    = tready_q;
    assign frame_count      = fcnt_q;
    assign good_frames      = good_q;
    assign last_line_words  = llw_q;
    assign last_frame_lines = lfl_q;
    assign err_line_len     = e_len_q;
    assign err_line_cnt     = e_cnt_q;
    assign err_data         = e_dat_q;
    assign err_framing      = e_frm_q;
    assign frame_done       = done_q;
    assign busy             = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_csi2_rx_frame_checker.sv
// Directed and randomized frames against a frame-level reference model
// for csi2_rx_frame_checker (8 beats/line, 4 lines/frame).
module tb_csi2_rx_frame_checker;

    localparam int WPL = 8;
    localparam int LPF = 4;
    localparam int CW  = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          enable = 1'b0;
    logic          clear_errs = 1'b0;
    logic          fs = 1'b0;
    logic          fe = 1'b0;
    logic [31:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [31:0]   frame_count;
    logic [31:0]   good_frames;
    logic [CW-1:0] last_line_words;
    logic [CW-1:0] last_frame_lines;
    logic          err_line_len;
    logic          err_line_cnt;
    logic          err_data;
    logic          err_framing;
    logic          frame_done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    int m_fc, m_good, m_llw, m_lfl;
    bit m_ell, m_elc, m_ed, m_ef;

    csi2_rx_frame_checker #(
        .DATA_WIDTH      (32),
        .WORDS_PER_LINE  (WPL),
        .LINES_PER_FRAME (LPF),
        .CNT_WIDTH       (CW),
        .CHECK_PATTERN   (1)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .enable           (enable),
        .clear_errs       (clear_errs),
        .fs               (fs),
        .fe               (fe),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .frame_count      (frame_count),
        .good_frames      (good_frames),
        .last_line_words  (last_line_words),
        .last_frame_lines (last_frame_lines),
        .err_line_len     (err_line_len),
        .err_line_cnt     (err_line_cnt),
        .err_data         (err_data),
        .err_framing      (err_framing),
        .frame_done       (frame_done),
        .busy             (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pat(input int ln, input int w);
        logic [31:0] v;
        for (int k = 0; k < 4; k++)
            v[8*k +: 8] = 8'((ln + 4 * w + k) % 256);
        return v;
    endfunction

    task automatic model_zero();
        m_fc = 0; m_good = 0; m_llw = 0; m_lfl = 0;
        m_ell = 0; m_elc = 0; m_ed = 0; m_ef = 0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".frame_count"}, frame_count, m_fc);
        chk({tag, ".good_frames"}, good_frames, m_good);
        chk({tag, ".last_line_words"}, 32'(last_line_words), m_llw);
        chk({tag, ".last_frame_lines"}, 32'(last_frame_lines), m_lfl);
        chk({tag, ".err_line_len"}, 32'(err_line_len), 32'(m_ell));
        chk({tag, ".err_line_cnt"}, 32'(err_line_cnt), 32'(m_elc));
        chk({tag, ".err_data"}, 32'(err_data), 32'(m_ed));
        chk({tag, ".err_framing"}, 32'(err_framing), 32'(m_ef));
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    task automatic do_clear();
        clear_errs = 1'b1;
        tick();
        clear_errs = 1'b0;
        model_zero();
    endtask

    // Send one frame: line sl has slen beats (others WPL), byte1 of beat bw
    // on line bl is corrupted; fe_last puts fe on the final tlast beat.
    task automatic run_frame(input string tag, input int nlines, input int sl,
                             input int slen, input int bl, input int bw,
                             input bit fe_last);
        int          len;
        bit          ferr;
        bit          corrupt;
        logic [31:0] d;
        ferr = 0;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        chk({tag, ".busy_fs"}, 32'(busy), 1);
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == sl) ? slen : WPL;
            for (int w = 0; w < len; w++) begin
                repeat ($urandom_range(0, 1)) tick();
                d = pat(ln, w);
                corrupt = (ln == bl && w == bw);
                if (corrupt)
                    d[15:8] = 8'hFF;
                s_axis_tdata  = d;
                s_axis_tvalid = 1'b1;
                s_axis_tlast  = (w == len - 1);
                fe = fe_last && (ln == nlines - 1) && (w == len - 1);
                tick();
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                s_axis_tdata  = $urandom;
                fe = 1'b0;
                if (corrupt) begin
                    m_ed = 1;
                    ferr = 1;
                    chk({tag, ".err_data_now"}, 32'(err_data), 1);
                end
                if (w == len - 1) begin
                    m_llw = len;
                    if (len != WPL) begin
                        m_ell = 1;
                        ferr  = 1;
                    end
                    chk({tag, ".line_words"}, 32'(last_line_words), len);
                end
            end
        end
        if (!fe_last) begin
            fe = 1'b1;
            tick();
            fe = 1'b0;
        end
        m_lfl = nlines;
        if (nlines != LPF) begin
            m_elc = 1;
            ferr  = 1;
        end
        m_fc++;
        if (!ferr)
            m_good++;
        chk({tag, ".frame_done"}, 32'(frame_done), 1);
        tick();
        chk({tag, ".frame_done_off"}, 32'(frame_done), 0);
        check_status(tag);
    endtask

    initial begin
        int nl, sl, slen, bl, bw;
        model_zero();
        tick();
        chk("rst.tready", 32'(s_axis_tready), 0);
        check_status("rst");
        sys_rst = 1'b0;
        enable  = 1'b1;
        tick();
        chk("rst.tready_up", 32'(s_axis_tready), 1);
        check_status("rst_rel");

        run_frame("t1", 4, -1, 0, -1, -1, 0);
        do_clear();
        check_status("t1clr");

        run_frame("t2", 4, 2, 7, -1, -1, 0);
        do_clear();

        run_frame("t3", 4, -1, 0, 1, 3, 0);
        do_clear();

        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h1234_5678;
        tick();
        s_axis_tvalid = 1'b0;
        m_ef = 1;
        chk("t4.framing_beat", 32'(err_framing), 1);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        chk("t4.frame_done", 32'(frame_done), 0);
        check_status("t4");
        do_clear();

        run_frame("t5", 4, -1, 0, -1, -1, 1);

        fs = 1'b1;
        tick();
        fs = 1'b0;
        for (int i = 0; i < 2 * WPL + 3; i++) begin
            s_axis_tdata  = pat(i / WPL, i % WPL);
            s_axis_tlast  = ((i % WPL) == WPL - 1);
            s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        sys_rst = 1'b1;
        #1;
        model_zero();
        chk("t6.rst_tready", 32'(s_axis_tready), 0);
        check_status("t6rst");
        tick();
        sys_rst = 1'b0;
        tick();
        run_frame("t6", 4, -1, 0, -1, -1, 0);
        do_clear();
        check_status("t6clr");

        for (int r = 0; r < 6; r++) begin
            nl   = $urandom_range(3, 5);
            sl   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            slen = $urandom_range(5, 9);
            bl   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            bw   = $urandom_range(0, 4);
            run_frame("rnd", nl, sl, slen, bl, bw, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
